// File: rtl/riscv_pkg.sv
// Shared RV32I encoding types: instruction formats, base opcodes, field bundle
// and the loader FSM state.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;

    localparam logic [6:0] OP_R    = 7'h33;
    localparam logic [6:0] OP_I    = 7'h13;
    localparam logic [6:0] OP_LOAD = 7'h03;
    localparam logic [6:0] OP_S    = 7'h23;
    localparam logic [6:0] OP_B    = 7'h63;
    localparam logic [6:0] OP_LUI  = 7'h37;
    localparam logic [6:0] OP_JAL  = 7'h6F;

    // Decoded field bundle as presented on the loader input
    typedef struct packed {
        logic [6:0]      funct7;
        logic [4:0]      rs2;
        logic [4:0]      rs1;
        logic [2:0]      funct3;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [XLEN-1:0] imm;
    } instr_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/instr_packer.sv
// Combinational packer: decoded fields plus format select -> 32-bit RV32I word.
// fmt_valid_c is low for the two unassigned format codes.
module instr_packer
    import riscv_pkg::*;
(
    input  logic [2:0]      fmt,
    input  instr_fields_t   fields,
    output logic [XLEN-1:0] word_c,
    output logic            fmt_valid_c
);

    always_comb begin
        word_c      = '0;
        fmt_valid_c = 1'b1;
        case (instr_fmt_t'(fmt))
            FMT_R: word_c = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                             fields.rd, fields.opcode};
            FMT_I: word_c = {fields.imm[11:0], fields.rs1, fields.funct3,
                             fields.rd, fields.opcode};
            FMT_S: word_c = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                             fields.imm[4:0], fields.opcode};
            // Branch/jump offsets are byte offsets; bit 0 is implied zero
            FMT_B: word_c = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                             fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
            FMT_U: word_c = {fields.imm[31:12], fields.rd, fields.opcode};
            FMT_J: word_c = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                             fields.imm[19:12], fields.rd, fields.opcode};
            default: fmt_valid_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: packs field bundles into RV32I words and streams them into
// instruction memory at consecutive word addresses, one registered write per accept.
module instr_encoder_loader
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err_fmt,
    output logic              err_ovf
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    load_state_t       state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              last_acc_q, last_acc_d;
    logic              err_fmt_q, err_fmt_d;
    logic              err_ovf_q, err_ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;

    instr_fields_t     fields_c;
    logic [XLEN-1:0]   packed_c;
    logic              fmt_valid_c;
    logic              full_c;
    logic              xfer_c;

    always_comb begin
        fields_c        = '0;
        fields_c.funct7 = funct7;
        fields_c.rs2    = rs2;
        fields_c.rs1    = rs1;
        fields_c.funct3 = funct3;
        fields_c.rd     = rd;
        fields_c.opcode = opcode;
        fields_c.imm    = imm;
    end

    instr_packer u_packer (
        .fmt         (in_fmt),
        .fields      (fields_c),
        .word_c      (packed_c),
        .fmt_valid_c (fmt_valid_c)
    );

    assign full_c   = (count_q == CNT_W'(DEPTH));
    // Reset masks the handshake and strobe so nothing moves in the reset cycle
    assign in_ready = (state_q == ST_LOAD) && (count_q < CNT_W'(DEPTH)) && !last_acc_q && !reset;
    assign xfer_c   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            last_acc_q <= 1'b0;
            err_fmt_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            last_acc_q <= last_acc_d;
            err_fmt_q  <= err_fmt_d;
            err_ovf_q  <= err_ovf_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    // Next state: leave LOAD one cycle after the final accept, so DONE follows the last write
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: if (last_acc_q || full_c) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_LOAD;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and flag updates
    always_comb begin
        count_d    = count_q;
        last_acc_d = last_acc_q;
        err_fmt_d  = err_fmt_q;
        err_ovf_d  = err_ovf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        if (state_q != ST_LOAD && start) begin
            count_d    = '0;
            last_acc_d = 1'b0;
            err_fmt_d  = 1'b0;
            err_ovf_d  = 1'b0;
        end

        if (xfer_c) begin
            if (fmt_valid_c) begin
                we_d    = 1'b1;
                addr_d  = ADDR_W'(BASE_ADDR) + count_q[ADDR_W-1:0];
                wdata_d = packed_c;
                count_d = count_q + CNT_W'(1);
            end else begin
                err_fmt_d = 1'b1;
            end
            if (in_last) last_acc_d = 1'b1;
        end

        if (state_q == ST_LOAD && full_c && !last_acc_q) err_ovf_d = 1'b1;
    end

    assign imem_we    = we_q && !reset;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = (state_q == ST_LOAD);
    assign done       = (state_q == ST_DONE);
    assign count      = count_q;
    assign err_fmt    = err_fmt_q;
    assign err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a transaction-level model checks one instance
// every cycle; a second small-DEPTH instance covers wrap and overflow.
module tb_instr_encoder_loader;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start_a, start_b, in_valid, in_last;
    logic [2:0]  in_fmt;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;

    logic        in_ready_a, imem_we_a, busy_a, done_a, err_fmt_a, err_ovf_a;
    logic [7:0]  imem_addr_a;
    logic [31:0] imem_wdata_a;
    logic [8:0]  count_a;
    logic        in_ready_b, imem_we_b, busy_b, done_b, err_fmt_b, err_ovf_b;
    logic [7:0]  imem_addr_b;
    logic [31:0] imem_wdata_b;
    logic [8:0]  count_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(256), .BASE_ADDR(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_fmt(in_fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .in_last(in_last), .imem_we(imem_we_a),
        .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a), .busy(busy_a), .done(done_a),
        .count(count_a), .err_fmt(err_fmt_a), .err_ovf(err_ovf_a));

    instr_encoder_loader #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(254)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_fmt(in_fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .in_last(in_last), .imem_we(imem_we_b),
        .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b), .busy(busy_b), .done(done_b),
        .count(count_b), .err_fmt(err_fmt_b), .err_ovf(err_ovf_b));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding built from shifted field values
    function automatic logic [31:0] model_pack(input logic [31:0] f, op, r_d, f3, r1, r2, f7, im);
        logic [31:0] base;
        base = op | (f3 << 12) | (r1 << 15);
        case (f)
            32'd0: return base | (r_d << 7) | (r2 << 20) | (f7 << 25);
            32'd1: return base | (r_d << 7) | ((im & 32'hFFF) << 20);
            32'd2: return base | ((im & 32'h1F) << 7) | (r2 << 20) | (((im >> 5) & 32'h7F) << 25);
            32'd3: return base | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                        | (r2 << 20) | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
            32'd4: return op | (r_d << 7) | (im & 32'hFFFFF000);
            32'd5: return op | (r_d << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
                        | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
            default: return 32'h0;
        endcase
    endfunction

    // Behavioural model of instance A (DEPTH 256, base 0)
    bit          started = 1'b0;
    bit          m_busy, m_done, m_last, m_ef, m_eo, m_we;
    int          m_count;
    logic [31:0] m_addr, m_wdata;

    always @(posedge clk) begin
        bit rdy;
        started = 1'b1;
        if (reset) begin
            m_busy = 0; m_done = 0; m_count = 0; m_last = 0; m_ef = 0; m_eo = 0; m_we = 0;
            m_addr = 0; m_wdata = 0;
        end else begin
            rdy  = m_busy && (m_count < 256) && !m_last;
            m_we = 0;
            if (m_busy) begin
                if (m_last || m_count == 256) begin
                    if (!m_last) m_eo = 1;
                    m_busy = 0;
                    m_done = 1;
                end else if (in_valid && rdy) begin
                    if (in_fmt <= 3'd5) begin
                        m_we    = 1;
                        m_addr  = 32'(m_count % 256);
                        m_wdata = model_pack(32'(in_fmt), 32'(opcode), 32'(rd), 32'(funct3),
                                             32'(rs1), 32'(rs2), 32'(funct7), imm);
                        m_count++;
                    end else begin
                        m_ef = 1;
                    end
                    if (in_last) m_last = 1;
                end
            end else if (start_a) begin
                m_busy = 1; m_done = 0; m_count = 0; m_last = 0; m_ef = 0; m_eo = 0;
            end
        end
    end

    // Per-cycle compare of instance A against the model, plus write capture
    logic [7:0]  qa_addr[$];
    logic [31:0] qa_data[$];
    logic [7:0]  qb_addr[$];
    int          nb_acc = 0;

    always @(negedge clk) begin
        if (started) begin
            check("a_we", 32'(imem_we_a), 32'(m_we && !reset));
            if (m_we && !reset) begin
                check("a_addr", 32'(imem_addr_a), m_addr);
                check("a_wdata", imem_wdata_a, m_wdata);
            end
            check("a_ready", 32'(in_ready_a), 32'(m_busy && m_count < 256 && !m_last && !reset));
            check("a_busy", 32'(busy_a), 32'(m_busy));
            check("a_done", 32'(done_a), 32'(m_done));
            check("a_count", 32'(count_a), 32'(m_count));
            check("a_err_fmt", 32'(err_fmt_a), 32'(m_ef));
            check("a_err_ovf", 32'(err_ovf_a), 32'(m_eo));
        end
        if (imem_we_a) begin qa_addr.push_back(imem_addr_a); qa_data.push_back(imem_wdata_a); end
        if (imem_we_b) qb_addr.push_back(imem_addr_b);
        if (in_valid && in_ready_b) nb_acc++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit to_b);
        @(posedge clk); #1;
        if (to_b) start_b = 1; else start_a = 1;
        @(posedge clk); #1;
        start_a = 0; start_b = 0;
    endtask

    // Present one bundle and hold it until accepted or the cycle budget runs out
    task automatic send(input bit to_b, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] r_d, input logic [2:0] f3, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [6:0] f7, input logic [31:0] im,
                        input logic last, input int budget, output bit acc);
        @(posedge clk); #1;
        in_fmt = f; opcode = op; rd = r_d; funct3 = f3; rs1 = r1; rs2 = r2;
        funct7 = f7; imm = im; in_last = last; in_valid = 1; acc = 0;
        for (int i = 0; i < budget && !acc; i++) begin
            @(negedge clk);
            if (to_b ? in_ready_b : in_ready_a) acc = 1;
            @(posedge clk);
        end
        #1 in_valid = 0; in_last = 0;
    endtask

    task automatic send_ok(input string name, input bit to_b, input logic [2:0] f,
                           input logic [6:0] op, input logic [4:0] r_d, input logic [2:0] f3,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [6:0] f7,
                           input logic [31:0] im, input logic last);
        bit acc;
        send(to_b, f, op, r_d, f3, r1, r2, f7, im, last, 20, acc);
        check(name, 32'(acc), 32'd1);
    endtask

    task automatic gap();
        int n;
        n = int'($urandom_range(0, 2));
        repeat (n) @(posedge clk);
    endtask

    initial begin
        bit acc;
        reset = 1; start_a = 0; start_b = 0; in_valid = 0; in_last = 0;
        in_fmt = 0; opcode = 0; rd = 0; funct3 = 0; rs1 = 0; rs2 = 0; funct7 = 0; imm = 0;
        cycles(2);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_count", 32'(count_a), 32'd0);
        check("rst_addr", 32'(imem_addr_a), 32'd0);
        check("rst_wdata", imem_wdata_a, 32'd0);
        check("rst_ready", 32'(in_ready_a), 32'd0);
        reset = 0;

        // Pin the model encoder against hand-assembled words
        check("pin_addi", model_pack(1, 32'(OP_I), 1, 0, 0, 0, 0, 5), 32'h00500093);
        check("pin_add", model_pack(0, 32'(OP_R), 3, 0, 1, 2, 0, 0), 32'h002081B3);
        check("pin_sw", model_pack(2, 32'(OP_S), 0, 2, 1, 2, 0, 8), 32'h0020A423);
        check("pin_beq", model_pack(3, 32'(OP_B), 0, 0, 1, 2, 0, 8), 32'h00208463);
        check("pin_jal", model_pack(5, 32'(OP_JAL), 1, 0, 0, 0, 0, 8), 32'h008000EF);
        check("pin_lui", model_pack(4, 32'(OP_LUI), 5, 0, 0, 0, 0, 32'h12345000), 32'h123452B7);

        // Load 1: I, R, S
        pulse_start(0);
        send_ok("acc_addi", 0, 3'd1, OP_I, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5, 0);
        send_ok("acc_add", 0, 3'd0, OP_R, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0, 0);
        send_ok("acc_sw", 0, 3'd2, OP_S, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8, 1);
        cycles(3);
        check("l1_nwrites", 32'(qa_addr.size()), 32'd3);
        if (qa_addr.size() == 3) begin
            check("l1_addr0", 32'(qa_addr[0]), 32'd0);
            check("l1_addr1", 32'(qa_addr[1]), 32'd1);
            check("l1_addr2", 32'(qa_addr[2]), 32'd2);
            check("l1_word0", qa_data[0], 32'h00500093);
            check("l1_word1", qa_data[1], 32'h002081B3);
            check("l1_word2", qa_data[2], 32'h0020A423);
        end
        check("l1_done", 32'(done_a), 32'd1);

        // Load 2: B, J, U with last on U
        qa_addr.delete(); qa_data.delete();
        pulse_start(0);
        send_ok("acc_beq", 0, 3'd3, OP_B, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'd8, 0);
        send_ok("acc_jal", 0, 3'd5, OP_JAL, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8, 0);
        send_ok("acc_lui", 0, 3'd4, OP_LUI, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h12345000, 1);
        cycles(3);
        check("l2_nwrites", 32'(qa_addr.size()), 32'd3);
        if (qa_addr.size() == 3) begin
            check("l2_word0", qa_data[0], 32'h00208463);
            check("l2_word1", qa_data[1], 32'h008000EF);
            check("l2_word2", qa_data[2], 32'h123452B7);
        end
        check("l2_done", 32'(done_a), 32'd1);
        check("l2_count", 32'(count_a), 32'd3);

        // Load 3: invalid format between valid bundles, random gaps, start ignored mid-load
        qa_addr.delete(); qa_data.delete();
        pulse_start(0);
        gap();
        send_ok("acc_v1", 0, 3'd1, OP_LOAD, 5'd4, 3'd2, 5'd3, 5'd0, 7'd0, 32'hFFC, 0);
        gap();
        send_ok("acc_bad", 0, 3'd6, OP_R, 5'd7, 3'd1, 5'd1, 5'd1, 7'h20, 32'd0, 0);
        pulse_start(0);
        check("l3_start_ignored", 32'(count_a), 32'd1);
        gap();
        send_ok("acc_v2", 0, 3'd0, OP_R, 5'd9, 3'd0, 5'd7, 5'd8, 7'h20, 32'd0, 1);
        cycles(3);
        check("l3_nwrites", 32'(qa_addr.size()), 32'd2);
        if (qa_addr.size() == 2) begin
            check("l3_addr0", 32'(qa_addr[0]), 32'd0);
            check("l3_addr1", 32'(qa_addr[1]), 32'd1);
        end
        check("l3_err_fmt", 32'(err_fmt_a), 32'd1);
        check("l3_count", 32'(count_a), 32'd2);

        // Restart from DONE clears flags; invalid last-bundle still finishes
        pulse_start(0);
        check("l4_err_clr", 32'(err_fmt_a), 32'd0);
        check("l4_count_clr", 32'(count_a), 32'd0);
        send_ok("acc_bad_last", 0, 3'd7, OP_I, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1, 1);
        cycles(2);
        check("l4_done", 32'(done_a), 32'd1);
        check("l4_err_fmt", 32'(err_fmt_a), 32'd1);

        // Reset the cycle after an accept aborts the write
        qa_addr.delete(); qa_data.delete();
        pulse_start(0);
        send_ok("acc_pre_rst", 0, 3'd1, OP_I, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 0);
        reset = 1;
        @(negedge clk);
        check("rst_mid_we", 32'(imem_we_a), 32'd0);
        @(posedge clk); #1;
        reset = 0;
        check("rst_mid_busy", 32'(busy_a), 32'd0);
        check("rst_mid_count", 32'(count_a), 32'd0);
        check("rst_mid_nwrites", 32'(qa_addr.size()), 32'd0);
        pulse_start(0);
        send_ok("acc_post_rst", 0, 3'd1, OP_I, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd3, 1);
        cycles(2);
        check("reload_nwrites", 32'(qa_addr.size()), 32'd1);
        if (qa_addr.size() == 1) check("reload_addr", 32'(qa_addr[0]), 32'd0);

        // Small instance: DEPTH 4 from base 254 wraps and overflows
        pulse_start(1);
        for (int i = 0; i < 5; i++) begin
            send(1, 3'd1, OP_I, 5'(i), 3'd0, 5'd0, 5'd0, 7'd0, 32'(i), 0, 6, acc);
            check("ovf_accept", 32'(acc), (i < 4) ? 32'd1 : 32'd0);
        end
        cycles(2);
        check("ovf_nacc", 32'(nb_acc), 32'd4);
        check("ovf_nwrites", 32'(qb_addr.size()), 32'd4);
        if (qb_addr.size() == 4) begin
            check("ovf_addr0", 32'(qb_addr[0]), 32'd254);
            check("ovf_addr1", 32'(qb_addr[1]), 32'd255);
            check("ovf_addr2", 32'(qb_addr[2]), 32'd0);
            check("ovf_addr3", 32'(qb_addr[3]), 32'd1);
        end
        check("ovf_err", 32'(err_ovf_b), 32'd1);
        check("ovf_done", 32'(done_b), 32'd1);
        check("ovf_count", 32'(count_b), 32'd4);
        check("ovf_ready", 32'(in_ready_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
